trigger_qualifier: RTL and testbench

//   Arms on a one-cycle enable and watches the external trigger pin for a qualified edge.
//   A qualified edge is the inactive level, then the active level held for trigger_length

---
 rtl/trigger_qualifier.sv | 218 +++++++++++++++++++++
 tb/tb_trigger_qualifier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_qualifier.sv
// ----------------------------------------------------------------------------
// trigger_qualifier
//   Arms on a one-cycle enable, then watches an asynchronous trigger pin for a
//   qualified edge: the inactive level followed by the active level held for
//   trigger_length consecutive synchronized samples. On qualification a single
//   cycle `triggered` pulse is produced (it drives the glitch delay enable).
//   Supports polarity select, an armed-time timeout, abort and a saturating
//   diagnostic count of qualified triggers.
//
// Ports
//   clk             system clock (single domain)
//   reset_n         synchronous reset, active-low
//   enable          one-cycle arm request, only honoured in IDLE
//   abort           forces IDLE on the next edge, suppresses any pulse
//   in              asynchronous trigger pin
//   active_low      0: active level high, 1: active level low (latched at arm)
//   trigger_length  consecutive active samples required, 0 acts as 1 (latched)
//   timeout         maximum armed cycles, 0 = never (latched at arm)
//   triggered       one-cycle pulse on qualification (registered)
//   timed_out       one-cycle pulse on timeout (registered)
//   busy            high while ARMED or QUALIFY (registered)
//   state           0 IDLE, 1 ARMED, 2 QUALIFY, 3 FIRE
//   trigger_count   qualified triggers since reset, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module trigger_qualifier #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             abort,
    input  logic             in,
    input  logic             active_low,
    input  logic [CNT_W-1:0] trigger_length,
    input  logic [CNT_W-1:0] timeout,
    output logic             triggered,
    output logic             timed_out,
    output logic             busy,
    output logic [1:0]       state,
    output logic [15:0]      trigger_count
);

    // A single-flop synchronizer is never acceptable, so clamp to two.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_QUALIFY = 2'd2,
        ST_FIRE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_N-1:0]  sync_q, sync_d;
    logic               active_low_q, active_low_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   timeout_q, timeout_d;
    logic               seen_inactive_q, seen_inactive_d;
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic               triggered_q, triggered_d;
    logic               timed_out_q, timed_out_d;
    logic               busy_q, busy_d;
    logic [15:0]        trigger_count_q, trigger_count_d;

    logic               in_s;
    logic               act_s;
    logic [CNT_W-1:0]   run_next_s;
    logic [CNT_W-1:0]   elapsed_next_s;
    logic               timeout_hit_s;

    assign in_s  = sync_q[SYNC_N-1];
    assign act_s = in_s ^ active_low_q;

    assign triggered     = triggered_q;
    assign timed_out     = timed_out_q;
    assign busy          = busy_q;
    assign state         = state_q;
    assign trigger_count = trigger_count_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        sync_d          = {sync_q[SYNC_N-2:0], in};
        state_d         = state_q;
        active_low_d    = active_low_q;
        len_d           = len_q;
        timeout_d       = timeout_q;
        seen_inactive_d = seen_inactive_q;
        elapsed_d       = elapsed_q;
        run_d           = run_q;
        timed_out_d     = 1'b0;

        run_next_s     = run_q + CNT_ONE;
        elapsed_next_s = elapsed_q + CNT_ONE;
        timeout_hit_s  = (timeout_q != CNT_ZERO) && (elapsed_next_s == timeout_q);

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    active_low_d    = active_low;
                    len_d           = (trigger_length == CNT_ZERO) ? CNT_ONE : trigger_length;
                    timeout_d       = timeout;
                    seen_inactive_d = 1'b0;
                    elapsed_d       = CNT_ZERO;
                    run_d           = CNT_ZERO;
                    state_d         = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!act_s) begin
                    seen_inactive_d = 1'b1;
                end else if (seen_inactive_q) begin
                    // First active sample after an inactive one counts as sample 1.
                    if (len_q == CNT_ONE) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_QUALIFY;
                        run_d   = CNT_ONE;
                    end
                end else begin
                    // Pin was already active at arm time: wait for it to drop.
                    state_d = ST_ARMED;
                end
            end
            ST_QUALIFY: begin
                if (act_s) begin
                    if (run_next_s == len_q) begin
                        state_d = ST_FIRE;
                    end else begin
                        run_d = run_next_s;
                    end
                end else begin
                    state_d         = ST_ARMED;
                    seen_inactive_d = 1'b1;
                    run_d           = CNT_ZERO;
                end
            end
            ST_FIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout only runs while waiting; elapsed is frozen when no timeout
        // is set so it can never wrap. A simultaneous qualification wins.
        if ((state_q == ST_ARMED) || (state_q == ST_QUALIFY)) begin
            if (timeout_q != CNT_ZERO) begin
                elapsed_d = elapsed_next_s;
            end else begin
                elapsed_d = elapsed_q;
            end
            if (timeout_hit_s && (state_d != ST_FIRE)) begin
                state_d     = ST_IDLE;
                timed_out_d = 1'b1;
            end else begin
                timed_out_d = 1'b0;
            end
        end else begin
            timed_out_d = 1'b0;
        end

        if (abort) begin
            state_d     = ST_IDLE;
            timed_out_d = 1'b0;
        end else begin
            timed_out_d = timed_out_d;
        end

        triggered_d = (state_d == ST_FIRE);
        busy_d      = (state_d == ST_ARMED) || (state_d == ST_QUALIFY);

        if (triggered_d && (trigger_count_q != 16'hFFFF)) begin
            trigger_count_d = trigger_count_q + 16'd1;
        end else begin
            trigger_count_d = trigger_count_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            sync_q          <= {SYNC_N{1'b0}};
            active_low_q    <= 1'b0;
            len_q           <= CNT_ZERO;
            timeout_q       <= CNT_ZERO;
            seen_inactive_q <= 1'b0;
            elapsed_q       <= CNT_ZERO;
            run_q           <= CNT_ZERO;
            triggered_q     <= 1'b0;
            timed_out_q     <= 1'b0;
            busy_q          <= 1'b0;
            trigger_count_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            active_low_q    <= active_low_d;
            len_q           <= len_d;
            timeout_q       <= timeout_d;
            seen_inactive_q <= seen_inactive_d;
            elapsed_q       <= elapsed_d;
            run_q           <= run_d;
            triggered_q     <= triggered_d;
            timed_out_q     <= timed_out_d;
            busy_q          <= busy_d;
            trigger_count_q <= trigger_count_d;
        end
    end

endmodule

// File: tb/tb_trigger_qualifier.sv
// ----------------------------------------------------------------------------
// tb_trigger_qualifier
//   Scoreboard bench: every expected output pulse (kind + cycle number) is
//   pushed when the stimulus that causes it is driven; a negedge monitor pops
//   and compares whenever triggered/timed_out is seen, and flags pulses that
//   arrive unexpectedly or not at all. Direct checks cover state, busy and
//   trigger_count at chosen points.
// ----------------------------------------------------------------------------
module tb_trigger_qualifier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        abort;
    logic        in;
    logic        active_low;
    logic [31:0] trigger_length;
    logic [31:0] timeout;
    logic        triggered;
    logic        timed_out;
    logic        busy;
    logic [1:0]  state;
    logic [15:0] trigger_count;

    trigger_qualifier #(.SYNC_STAGES(2), .CNT_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .abort          (abort),
        .in             (in),
        .active_low     (active_low),
        .trigger_length (trigger_length),
        .timeout        (timeout),
        .triggered      (triggered),
        .timed_out      (timed_out),
        .busy           (busy),
        .state          (state),
        .trigger_count  (trigger_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_trig;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_count;
    int          k;
    int          a;

    // Posedge counter used as the time base for expected pulse cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit is_trig, input int c);
        exp_q.push_back('{is_trig: is_trig, cyc: c});
    endtask

    task automatic arm(input logic al, input logic [31:0] len, input logic [31:0] to);
        active_low     = al;
        trigger_length = len;
        timeout        = to;
        enable         = 1'b1;
        step(1);
        enable         = 1'b0;
    endtask

    // Scoreboard monitor: compares observed pulses against queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_missing", 64'(cyc), 64'(mon_e.cyc));
            end
            if (triggered || timed_out) begin
                check_eq("pulse_exclusive", 64'(triggered & timed_out), 64'd0);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_pulse", 64'({triggered, timed_out}), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check_eq("pulse_is_trig", 64'(triggered), 64'(mon_e.is_trig));
                    check_eq("pulse_is_timeout", 64'(timed_out), 64'(!mon_e.is_trig));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; abort = 1'b0; in = 1'b0;
        active_low = 1'b0; trigger_length = 32'd0; timeout = 32'd0;
        exp_count = 16'd0;
        step(4);
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_triggered", 64'(triggered), 64'd0);
        check_eq("rst_timed_out", 64'(timed_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_count", 64'(trigger_count), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(3);

        // 1: len=3, rise 10 cycles after arm, pulse 5 posedges after rise
        arm(1'b0, 32'd3, 32'd0);
        check_eq("t1_armed", 64'(state), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd1);
        step(9);
        in = 1'b1; k = cyc; push_exp(1'b1, k + 5);
        step(3); check_eq("t1_qualify", 64'(state), 64'd2);
        step(2); check_eq("t1_fire", 64'(state), 64'd3);
        step(1); check_eq("t1_idle", 64'(state), 64'd0);
        exp_count = exp_count + 16'd1;
        check_eq("t1_count", 64'(trigger_count), 64'(exp_count));
        in = 1'b0; step(4);

        // 2: len=4, high 2 / low 1 / high 6 -> restart, fire on 4th sample of 2nd burst
        arm(1'b0, 32'd4, 32'd0);
        step(3);
        in = 1'b1; k = cyc; push_exp(1'b1, k + 9);
        step(2); in = 1'b0;
        step(1); in = 1'b1;
        step(1); check_eq("t2_qualify", 64'(state), 64'd2);
        step(1); check_eq("t2_back_armed", 64'(state), 64'd1);
        step(4); in = 1'b0;
        step(1); check_eq("t2_idle", 64'(state), 64'd0);
        exp_count = exp_count + 16'd1;
        check_eq("t2_count", 64'(trigger_count), 64'(exp_count));
        step(3);

        // 3: pin already active at arm -> needs a fresh inactive->active edge
        in = 1'b1; step(3);
        arm(1'b0, 32'd2, 32'd0);
        step(50); check_eq("t3_still_armed", 64'(state), 64'd1);
        step(47); in = 1'b0;
        step(3); in = 1'b1; k = cyc; push_exp(1'b1, k + 4);
        step(6); check_eq("t3_idle", 64'(state), 64'd0);
        exp_count = exp_count + 16'd1;
        check_eq("t3_count", 64'(trigger_count), 64'(exp_count));
        in = 1'b0; step(3);

        // 4a: timeout=50 with pin held inactive
        a = cyc; push_exp(1'b0, a + 51);
        arm(1'b0, 32'd2, 32'd50);
        check_eq("t4_busy", 64'(busy), 64'd1);
        step(49); check_eq("t4_armed_before_to", 64'(state), 64'd1);
        step(1);  check_eq("t4_idle_after_to", 64'(state), 64'd0);
        check_eq("t4_count", 64'(trigger_count), 64'(exp_count));
        step(2);

        // 4b: timeout lands on the qualification edge -> triggered only
        a = cyc;
        arm(1'b0, 32'd3, 32'd15);
        step(10);
        in = 1'b1; k = cyc; push_exp(1'b1, k + 5);
        step(6); check_eq("t4b_idle", 64'(state), 64'd0);
        exp_count = exp_count + 16'd1;
        check_eq("t4b_count", 64'(trigger_count), 64'(exp_count));
        in = 1'b0; step(4);

        // 5a: abort in QUALIFY
        arm(1'b0, 32'd5, 32'd0);
        step(3);
        in = 1'b1;
        step(3); check_eq("t5_qualify", 64'(state), 64'd2);
        abort = 1'b1;
        step(1); abort = 1'b0;
        check_eq("t5_abort_idle", 64'(state), 64'd0);
        check_eq("t5_abort_busy", 64'(busy), 64'd0);
        step(10);
        check_eq("t5_abort_count", 64'(trigger_count), 64'(exp_count));
        in = 1'b0; step(4);

        // 5b: reset in QUALIFY
        arm(1'b0, 32'd5, 32'd0);
        step(3);
        in = 1'b1;
        step(3); check_eq("t5b_qualify", 64'(state), 64'd2);
        reset_n = 1'b0;
        step(1);
        check_eq("t5b_rst_state", 64'(state), 64'd0);
        check_eq("t5b_rst_count", 64'(trigger_count), 64'd0);
        check_eq("t5b_rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1; exp_count = 16'd0;
        in = 1'b0; step(4);

        // 6: active-low, len=1, enable while busy and in FIRE ignored
        in = 1'b1; step(3);
        arm(1'b1, 32'd1, 32'd0);
        check_eq("t6_armed", 64'(state), 64'd1);
        step(1);
        active_low = 1'b0; trigger_length = 32'd8; timeout = 32'd3; enable = 1'b1;
        step(1); enable = 1'b0;
        active_low = 1'b1; trigger_length = 32'd1; timeout = 32'd0;
        check_eq("t6_enable_busy_ignored", 64'(state), 64'd1);
        step(5); check_eq("t6_no_relatch", 64'(state), 64'd1);
        in = 1'b0; k = cyc; push_exp(1'b1, k + 3);
        step(3); check_eq("t6_fire", 64'(state), 64'd3);
        enable = 1'b1;
        step(1); enable = 1'b0;
        check_eq("t6_enable_fire_ignored", 64'(state), 64'd0);
        exp_count = exp_count + 16'd1;
        check_eq("t6_count", 64'(trigger_count), 64'(exp_count));

        // 6: saturation, counter preloaded just below the limit
        force dut.trigger_count_q = 16'hFFFD;
        step(1);
        release dut.trigger_count_q;
        step(1);
        exp_count = 16'hFFFD;
        check_eq("sat_preload", 64'(trigger_count), 64'(exp_count));
        for (int i = 0; i < 4; i++) begin
            in = 1'b1; step(3);
            arm(1'b1, 32'd1, 32'd0);
            step(2);
            in = 1'b0; k = cyc; push_exp(1'b1, k + 3);
            step(4);
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            check_eq("sat_count", 64'(trigger_count), 64'(exp_count));
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
